// File: rtl/branch_pkg.sv
// Shared constants, counter encodings and result payload for the branch unit.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic valid;
        logic taken;
        logic mispredict;
    } res_t;

    // Saturating step of a 2-bit counter toward the resolved direction.
    function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        case (c)
            CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
            default: n = CTR_WNT;
        endcase
        return n;
    endfunction

    // True when the counter state predicts taken.
    function automatic logic ctr_predicts_taken(input ctr_e c);
        return (c == CTR_WT) || (c == CTR_ST);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: decodes funct3 legality and
// computes the taken outcome over the full operand width.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            legal
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (rs1 == rs2);
    assign w_lt_s = ($signed(rs1) < $signed(rs2));
    assign w_lt_u = (rs1 < rs2);

    // funct3 010/011 are reserved and never resolve as taken.
    always_comb begin
        taken = 1'b0;
        legal = 1'b0;
        case (funct3)
            BEQ: begin
                legal = 1'b1;
                taken = w_eq;
            end
            BNE: begin
                legal = 1'b1;
                taken = ~w_eq;
            end
            BLT: begin
                legal = 1'b1;
                taken = w_lt_s;
            end
            BGE: begin
                legal = 1'b1;
                taken = ~w_lt_s;
            end
            BLTU: begin
                legal = 1'b1;
                taken = w_lt_u;
            end
            BGEU: begin
                legal = 1'b1;
                taken = ~w_lt_u;
            end
            default: begin
                legal = 1'b0;
                taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit with a bimodal 2-bit-counter prediction table;
// fetch reads the table combinationally, execute resolves and trains it.
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);

    ctr_e           r_bht [BHT_ENTRIES];
    res_t           r_res;

    logic [IDX-1:0] w_fetch_idx;
    logic [IDX-1:0] w_ex_idx;
    ctr_e           w_fetch_ctr;
    ctr_e           w_ex_ctr;
    ctr_e           w_ex_ctr_next;
    logic           w_cmp_taken;
    logic           w_cmp_legal;
    logic           w_branch;
    res_t           w_res_next;
    logic           w_unused_pc;

    // Word-aligned PCs: bits [1:0] and everything above the index alias freely.
    assign w_fetch_idx = fetch_pc[IDX+1:2];
    assign w_ex_idx    = ex_pc[IDX+1:2];
    assign w_unused_pc = ^{fetch_pc[XLEN-1:IDX+2], fetch_pc[1:0],
                           ex_pc[XLEN-1:IDX+2], ex_pc[1:0]};

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .funct3 (ex_funct3),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .taken  (w_cmp_taken),
        .legal  (w_cmp_legal)
    );

    assign w_branch = ex_valid && (ex_opcode == OP_BRANCH) && w_cmp_legal;

    // Prediction reads the registered table, so a same-cycle update is not seen.
    assign w_fetch_ctr   = r_bht[w_fetch_idx];
    assign pred_taken    = ctr_predicts_taken(w_fetch_ctr);

    assign w_ex_ctr      = r_bht[w_ex_idx];
    assign w_ex_ctr_next = ctr_step(w_ex_ctr, w_cmp_taken);

    always_comb begin
        w_res_next = '0;
        if (w_branch) begin
            w_res_next.valid      = 1'b1;
            w_res_next.taken      = w_cmp_taken;
            w_res_next.mispredict = w_cmp_taken ^ ex_pred_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else begin
            r_res <= w_res_next;
        end
    end

    // Table training: only a legal resolved branch moves its entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[IDX'(i)] <= CTR_WNT;
            end
        end else if (w_branch) begin
            r_bht[w_ex_idx] <= w_ex_ctr_next;
        end
    end

    assign res_valid      = r_res.valid;
    assign res_taken      = r_res.taken;
    assign res_mispredict = r_res.mispredict;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus a randomized
// run against a counter-table reference model.
module tb_branch_unit;

    localparam int XLEN = 32;
    localparam int BHT  = 64;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic            ex_valid;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic            ex_pred_taken;
    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;

    int checks   = 0;
    int failures = 0;
    int model_ctr [BHT];

    branch_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (BHT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pred_taken  (ex_pred_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_br(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic pt);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_rs1        = a;
        ex_rs2        = b;
        ex_pred_taken = pt;
    endtask

    task automatic drive_idle();
        ex_valid      = 1'b0;
        ex_opcode     = 7'd0;
        ex_funct3     = 3'd0;
        ex_pc         = 32'd0;
        ex_rs1        = 32'd0;
        ex_rs2        = 32'd0;
        ex_pred_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference outcome from the architectural branch rules.
    function automatic void ref_outcome(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, output bit legal, output bit tk);
        int sa;
        int sb;
        sa = a;
        sb = b;
        legal = 1'b1;
        tk    = 1'b0;
        case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = (sa < sb);
            3'd5: tk = (sa >= sb);
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        drive_idle();
        fetch_pc = 32'h40;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, res_taken, res_mispredict} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000", {res_valid, res_taken, res_mispredict});
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_pred got=%b exp=0", pred_taken);
        end
        // Branch held while in reset must be discarded.
        drive_br(32'h40, OP_BR, 3'd0, 32'd5, 32'd5, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        drive_idle();
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard_valid got=%b exp=0", res_valid);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard_table got=%b exp=0", pred_taken);
        end
    endtask

    task automatic test_basic();
        fetch_pc = 32'h40;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL basic_pred_before got=%b exp=0", pred_taken);
        end
        drive_br(32'h40, OP_BR, 3'd0, 32'd5, 32'd5, 1'b0);
        tick();
        drive_idle();
        checks++;
        if ({res_valid, res_taken, res_mispredict} !== 3'b111) begin
            failures++;
            $display("FAIL basic_result got=%b exp=111", {res_valid, res_taken, res_mispredict});
        end
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL basic_pred_after got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_compare();
        logic [2:0]  f3s [6] = '{3'd4, 3'd6, 3'd7, 3'd5, 3'd1, 3'd0};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7, 32'h1_0000};
        logic [31:0] bs  [6] = '{32'h1, 32'h1, 32'h1, 32'h7FFF_FFFF, 32'h7, 32'h0};
        logic        exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive_br(32'hC0, OP_BR, f3s[i], as[i], bs[i], 1'b1);
            tick();
            drive_idle();
            checks++;
            if ({res_valid, res_taken, res_mispredict} !== {1'b1, exp[i], ~exp[i]}) begin
                failures++;
                $display("FAIL compare_%0d got=%b exp=%b", i,
                         {res_valid, res_taken, res_mispredict}, {1'b1, exp[i], ~exp[i]});
            end
        end
    endtask

    task automatic test_saturate();
        fetch_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            drive_br(32'h80, OP_BR, 3'd0, 32'd1, 32'd1, 1'b0);
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL sat_st_pred got=%b exp=1", pred_taken);
        end
        for (int i = 0; i < 4; i++) begin
            drive_br(32'h80, OP_BR, 3'd1, 32'd1, 32'd1, 1'b1);
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL sat_snt_pred got=%b exp=0", pred_taken);
        end
        // SNT + taken = WNT (still not taken); + taken again = WT.
        drive_br(32'h80, OP_BR, 3'd0, 32'd2, 32'd2, 1'b0);
        tick();
        drive_idle();
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL sat_wnt_pred got=%b exp=0", pred_taken);
        end
        drive_br(32'h80, OP_BR, 3'd0, 32'd2, 32'd2, 1'b0);
        tick();
        drive_idle();
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL sat_wt_pred got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_illegal();
        // Entry 0x40 is WT from test_basic.
        fetch_pc = 32'h40;
        drive_br(32'h40, OP_BR, 3'd2, 32'd3, 32'd9, 1'b1);
        tick();
        checks++;
        if ({res_valid, res_taken, res_mispredict} !== 3'b000) begin
            failures++;
            $display("FAIL illegal_f3 got=%b exp=000", {res_valid, res_taken, res_mispredict});
        end
        drive_br(32'h40, OP_ALU, 3'd0, 32'd3, 32'd9, 1'b1);
        tick();
        checks++;
        if ({res_valid, res_taken, res_mispredict} !== 3'b000) begin
            failures++;
            $display("FAIL illegal_op got=%b exp=000", {res_valid, res_taken, res_mispredict});
        end
        drive_br(32'h40, OP_BR, 3'd1, 32'd3, 32'd9, 1'b1);
        ex_valid = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_invalid got=%b exp=0", res_valid);
        end
        drive_idle();
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL illegal_table_kept got=%b exp=1", pred_taken);
        end
        // One not-taken from WT lands on WNT only if the entry was untouched.
        drive_br(32'h40, OP_BR, 3'd1, 32'd4, 32'd4, 1'b1);
        tick();
        drive_idle();
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL illegal_table_wt got=%b exp=0", pred_taken);
        end
    endtask

    task automatic test_collision();
        fetch_pc = 32'h100;
        drive_br(32'h100, OP_BR, 3'd0, 32'd8, 32'd8, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL collide_same_cycle got=%b exp=0", pred_taken);
        end
        tick();
        drive_idle();
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL collide_next_cycle got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_async_reset();
        drive_br(32'h204, OP_BR, 3'd0, 32'd1, 32'd1, 1'b0);
        tick();
        drive_br(32'h308, OP_BR, 3'd0, 32'd1, 32'd1, 1'b0);
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_valid got=%b exp=1", res_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, res_taken, res_mispredict} !== 3'b000) begin
            failures++;
            $display("FAIL async_outputs got=%b exp=000", {res_valid, res_taken, res_mispredict});
        end
        tick();
        fetch_pc = 32'h204;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL async_entry_204 got=%b exp=0", pred_taken);
        end
        fetch_pc = 32'h308;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL async_entry_308 got=%b exp=0", pred_taken);
        end
        // First edge after release must resolve normally; WNT + taken = WT.
        rst_n = 1'b1;
        tick();
        drive_idle();
        checks++;
        if ({res_valid, res_taken, res_mispredict} !== 3'b111) begin
            failures++;
            $display("FAIL async_first_edge got=%b exp=111", {res_valid, res_taken, res_mispredict});
        end
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL async_entry_wnt got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_random();
        int          idx_pool [4] = '{5, 6, 7, 40};
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        v;
        logic        pt;
        bit          legal;
        bit          tk;
        bit          is_br;
        int          ei;
        int          fi;
        rst_n = 1'b0;
        drive_idle();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < BHT; i++) model_ctr[i] = 1;
        for (int n = 0; n < 400; n++) begin
            fi = idx_pool[$urandom_range(0, 3)];
            ei = idx_pool[$urandom_range(0, 3)];
            fetch_pc = ($urandom & 32'hFFFF_FF00) | (fi * 4) | $urandom_range(0, 3);
            pc       = ($urandom & 32'hFFFF_FF00) | (ei * 4) | $urandom_range(0, 3);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = ($urandom_range(0, 7) == 0) ? OP_ALU : OP_BR;
            f3 = 3'($urandom_range(0, 7));
            v  = ($urandom_range(0, 9) != 0);
            pt = 1'($urandom_range(0, 1));
            drive_br(pc, op, f3, a, b, pt);
            ex_valid = v;
            #1;
            checks++;
            if (pred_taken !== (model_ctr[fi] >= 2)) begin
                failures++;
                $display("FAIL rand_pred n=%0d got=%b exp=%b", n, pred_taken, model_ctr[fi] >= 2);
            end
            ref_outcome(f3, a, b, legal, tk);
            is_br = v && (op == OP_BR) && legal;
            tick();
            checks++;
            if ({res_valid, res_taken, res_mispredict} !== {is_br, is_br & tk, is_br & (tk ^ pt)}) begin
                failures++;
                $display("FAIL rand_res n=%0d got=%b exp=%b", n,
                         {res_valid, res_taken, res_mispredict}, {is_br, is_br & tk, is_br & (tk ^ pt)});
            end
            if (is_br) begin
                if (tk) model_ctr[ei] = (model_ctr[ei] == 3) ? 3 : model_ctr[ei] + 1;
                else    model_ctr[ei] = (model_ctr[ei] == 0) ? 0 : model_ctr[ei] - 1;
            end
        end
        drive_idle();
    endtask

    initial begin
        rst_n    = 1'b1;
        fetch_pc = 32'd0;
        drive_idle();
        test_reset();
        test_basic();
        test_compare();
        test_saturate();
        test_illegal();
        test_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
